// File: rtl/vram_write_arbiter.sv
// Frame-buffer write arbiter: buffered EBI writes share one RAM write port with
// a block-fill engine; EBI wins unless fill has been starved for FAIR_N grants.
module vram_write_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FAIR_N     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ebi_valid,
  input  logic [ADDR_W-1:0]             ebi_addr,
  input  logic [DATA_W-1:0]             ebi_data,
  input  logic                          fill_start,
  input  logic [ADDR_W-1:0]             fill_base,
  input  logic [ADDR_W-1:0]             fill_len,
  input  logic [DATA_W-1:0]             fill_data,
  output logic                          write_enable,
  output logic [ADDR_W-1:0]             write_address,
  output logic [DATA_W-1:0]             data_out,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FAIR_N + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef enum logic {IDLE, FILL} state_t;

  wr_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  state_t           r_state, w_next;
  logic [ADDR_W-1:0] r_faddr, r_rem;
  logic [DATA_W-1:0] r_fdata;
  logic [CNT_W-1:0] r_fair;
  logic             r_we, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic w_empty, w_full, w_push, w_pop;
  logic w_fill_act, w_fair_hold, w_gnt_ebi, w_gnt_fill, w_last, w_accept;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_gnt_ebi;
  // A push into a full FIFO still lands when the same cycle pops an entry.
  assign w_push  = ebi_valid && (!w_full || w_pop);
  assign w_accept = (r_state == IDLE) && fill_start && (fill_len != '0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = FILL;
      FILL: if (w_last)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs: grant selection
  always_comb begin
    w_fill_act  = (r_state == FILL);
    w_fair_hold = w_fill_act && (r_fair == CNT_W'(FAIR_N));
    w_gnt_ebi   = !w_empty && !w_fair_hold;
    w_gnt_fill  = w_fill_act && !w_gnt_ebi;
    w_last      = w_gnt_fill && (r_rem == ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {ebi_addr, ebi_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (ebi_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_faddr <= '0;
      r_rem   <= '0;
      r_fdata <= '0;
      r_fair  <= '0;
    end else begin
      if (w_accept) begin
        r_faddr <= fill_base;
        r_rem   <= fill_len;
        r_fdata <= fill_data;
      end else if (w_gnt_fill) begin
        r_faddr <= r_faddr + ADDR_W'(1);
        r_rem   <= r_rem - ADDR_W'(1);
      end
      if (!w_fill_act || w_gnt_fill) r_fair <= '0;
      else if (w_gnt_ebi)            r_fair <= r_fair + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_we   <= w_gnt_ebi || w_gnt_fill;
      r_done <= w_last;
      if (w_gnt_ebi) begin
        r_addr <= r_mem[r_rptr].addr;
        r_data <= r_mem[r_rptr].data;
      end else if (w_gnt_fill) begin
        r_addr <= r_faddr;
        r_data <= r_fdata;
      end
    end
  end

  assign write_enable  = r_we;
  assign write_address = r_addr;
  assign data_out      = r_data;
  assign fill_done     = r_done;
  assign fill_busy     = (r_state == FILL) || r_done;
  assign fifo_overflow = r_ovf;
  assign fifo_level    = r_level;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: latency, wrap fill, ignored starts,
// fairness, overflow and mid-fill reset.
module tb_vram_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ebi_valid, fill_start;
  logic [15:0] ebi_addr, ebi_data, fill_base, fill_len, fill_data;
  logic        write_enable, fill_busy, fill_done, fifo_overflow;
  logic [15:0] write_address, data_out;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        busy;
  } wr_t;
  wr_t q[$];
  int  done_cnt;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .clk(clk), .reset(reset),
    .ebi_valid(ebi_valid), .ebi_addr(ebi_addr), .ebi_data(ebi_data),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
    .write_enable(write_enable), .write_address(write_address), .data_out(data_out),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .fifo_overflow(fifo_overflow), .fifo_level(fifo_level)
  );

  always @(negedge clk) begin
    if (!reset && write_enable) q.push_back('{write_address, data_out, fill_busy});
    if (!reset && fill_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    q.delete(); done_cnt = 0;
  endtask

  task automatic start_fill(input logic [15:0] base, input logic [15:0] len, input logic [15:0] dat);
    fill_start = 1'b1; fill_base = base; fill_len = len; fill_data = dat;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    int n_fill, n_ebi, run, max_run, bad_ord;
    reset = 1'b1; ebi_valid = 0; fill_start = 0;
    ebi_addr = 0; ebi_data = 0; fill_base = 0; fill_len = 0; fill_data = 0;
    done_cnt = 0;
    repeat (3) tick();
    chk("rst_we", write_enable, 0);   chk("rst_addr", write_address, 0);
    chk("rst_data", data_out, 0);     chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);    chk("rst_ovf", fifo_overflow, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0; tick();

    // single EBI write: valid in cycle N, write in N+2
    ebi_valid = 1; ebi_addr = 16'h0123; ebi_data = 16'h0ABC;
    tick(); ebi_valid = 0;
    chk("ebi_n1_we", write_enable, 0); chk("ebi_n1_level", fifo_level, 1);
    tick();
    chk("ebi_n2_we", write_enable, 1); chk("ebi_n2_addr", write_address, 16'h0123);
    chk("ebi_n2_data", data_out, 16'h0ABC); chk("ebi_n2_level", fifo_level, 0);
    tick();
    chk("ebi_n3_we", write_enable, 0); chk("ebi_n3_hold", write_address, 16'h0123);

    // wrap-around fill
    start_fill(16'hFFFE, 16'd4, 16'h00F0);
    chk("wrap_busy_n1", fill_busy, 1); chk("wrap_we_n1", write_enable, 0);
    tick();
    chk("wrap_w0_we", write_enable, 1); chk("wrap_w0_addr", write_address, 16'hFFFE);
    chk("wrap_w0_data", data_out, 16'h00F0); chk("wrap_w0_done", fill_done, 0);
    tick(); chk("wrap_w1_addr", write_address, 16'hFFFF);
    tick(); chk("wrap_w2_addr", write_address, 16'h0000); chk("wrap_w2_done", fill_done, 0);
    tick();
    chk("wrap_w3_addr", write_address, 16'h0001); chk("wrap_w3_done", fill_done, 1);
    chk("wrap_w3_busy", fill_busy, 1);
    tick();
    chk("wrap_end_busy", fill_busy, 0); chk("wrap_end_done", fill_done, 0);
    chk("wrap_end_we", write_enable, 0);

    // ignored starts: zero length, and a start while filling
    q.delete(); done_cnt = 0;
    start_fill(16'h4000, 16'd0, 16'h1111);
    chk("len0_busy", fill_busy, 0);
    repeat (3) tick();
    chk("len0_writes", q.size(), 0); chk("len0_done", done_cnt, 0);
    start_fill(16'h1000, 16'd3, 16'h0055);
    tick();
    start_fill(16'h5000, 16'd5, 16'h2222);
    repeat (8) tick();
    chk("ign_writes", q.size(), 3);
    if (q.size() == 3) chk("ign_last_addr", q[2].a, 16'h1002);
    chk("ign_done", done_cnt, 1); chk("ign_busy", fill_busy, 0);
    chk("ign_ovf", fifo_overflow, 0);

    // fairness: EBI strobe every cycle during an 8-word fill
    do_reset();
    start_fill(16'h1000, 16'd8, 16'hF111);
    for (int i = 1; i <= 100; i++) begin
      ebi_valid = 1; ebi_addr = 16'h2000 + 16'(i); ebi_data = 16'(i);
      tick();
      if (!fill_busy) break;
    end
    ebi_valid = 0;
    repeat (8) tick();
    chk("fair_timeout", fill_busy, 0);
    n_fill = 0; run = 0; max_run = 0;
    foreach (q[k]) begin
      if (q[k].a[15:12] == 4'h1) begin n_fill++; run = 0; end
      else if (q[k].busy) begin run++; if (run > max_run) max_run = run; end
    end
    chk("fair_fill_cnt", n_fill, 8);
    chk("fair_max_run", max_run, 4);
    chk("fair_done", done_cnt, 1);

    // overflow: 21 pushes during a 100-word fill; the 21st meets a full FIFO on a fill slot
    do_reset();
    start_fill(16'h1000, 16'd100, 16'hF111);
    for (int i = 1; i <= 21; i++) begin
      ebi_valid = 1; ebi_addr = 16'h2000 + 16'(i); ebi_data = 16'(i);
      tick();
      if (i == 20) begin chk("ovf_pre", fifo_overflow, 0); chk("ovf_full", fifo_level, 4); end
    end
    ebi_valid = 0;
    chk("ovf_set", fifo_overflow, 1); chk("ovf_level", fifo_level, 4);
    for (int i = 0; i < 300 && fill_busy; i++) tick();
    repeat (6) tick();
    chk("ovf_fill_end", fill_busy, 0);
    n_fill = 0; n_ebi = 0; bad_ord = 0;
    foreach (q[k]) begin
      if (q[k].a[15:12] == 4'h1) n_fill++;
      else begin
        n_ebi++;
        if (q[k].a != 16'h2000 + 16'(n_ebi) || q[k].d != 16'(n_ebi)) bad_ord++;
      end
    end
    chk("ovf_ebi_cnt", n_ebi, 20); chk("ovf_ebi_order", bad_ord, 0);
    chk("ovf_fill_cnt", n_fill, 100); chk("ovf_sticky", fifo_overflow, 1);

    // reset after 3 of 10 fill words
    do_reset();
    start_fill(16'h3000, 16'd10, 16'h0777);
    repeat (3) tick();
    chk("mrst_w3_addr", write_address, 16'h3002); chk("mrst_w3_we", write_enable, 1);
    reset = 1'b1; #1;
    chk("mrst_we", write_enable, 0);  chk("mrst_addr", write_address, 0);
    chk("mrst_data", data_out, 0);    chk("mrst_busy", fill_busy, 0);
    chk("mrst_done", fill_done, 0);   chk("mrst_level", fifo_level, 0);
    tick(); reset = 1'b0; q.delete(); done_cnt = 0;
    repeat (15) tick();
    chk("mrst_no_writes", q.size(), 0); chk("mrst_idle", fill_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
